// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART blocks.
// Contents:
//   uart_state_t   receiver state encoding (3-bit)
//   CLK_HZ, BAUD   default system clock and line rate
//   PAR_EVEN/ODD   parity-mode encodings
//   calc_clk_div   rounds clk_hz / (baud * oversample) to the nearest integer
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int unsigned CLK_HZ         = 50_000_000;
  localparam int unsigned BAUD           = 115200;
  localparam int unsigned DEF_OVERSAMPLE = 16;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic int unsigned calc_clk_div(input int unsigned clk_hz,
                                               input int unsigned baud,
                                               input int unsigned oversample);
    int unsigned rate;
    rate = baud * oversample;
    return (clk_hz + rate / 2) / rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator.
// Ports:
//   clk    system clock
//   n_rst  asynchronous active-low reset
//   en     count enable; low holds the divider at 0
//   tick   one-clk pulse when the divider reaches CLK_DIV-1
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = calc_clk_div(CLK_HZ, BAUD, DEF_OVERSAMPLE)
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // With CLK_DIV = 1 the counter sits at 0 = LAST, so tick follows en.
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF input synchroniser, oversampled mid-bit
// sampling, false-start rejection, parity and framing error reporting.
// Ports:
//   clk         system clock
//   n_rst       asynchronous active-low reset
//   rx_en       receiver enable; low aborts any frame and clears the divider
//   rxd         asynchronous serial input, idle high
//   rx_data     last received word (LSB first on the line)
//   rx_valid    one-clk pulse per completed frame
//   parity_err  parity mismatch, qualified by rx_valid
//   frame_err   a stop bit sampled low, qualified by rx_valid
//   busy        receiver not in IDLE
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 27,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rx_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] B_DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic PAR_EXPECT = PARITY_ODD ? PAR_ODD : PAR_EVEN;

  logic rxd_m, rxd_s;
  logic tick;

  uart_state_t          state;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc;
  logic                 par_flag;
  logic                 frm_flag;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (rx_en),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      scnt       <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_flag   <= 1'b0;
      frm_flag   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (!rx_en) begin
        // Abort: outputs keep the last frame's values, in-flight flags drop.
        state    <= IDLE;
        scnt     <= '0;
        bcnt     <= '0;
        par_acc  <= 1'b0;
        par_flag <= 1'b0;
        frm_flag <= 1'b0;
      end else if (tick) begin
        case (state)
          IDLE: begin
            if (!rxd_s) begin
              state <= START;
              scnt  <= '0;
            end
          end
          START: begin
            if (scnt == S_MID) begin
              scnt <= '0;
              if (rxd_s) begin
                state <= IDLE;
              end else begin
                state    <= DATA;
                bcnt     <= '0;
                par_acc  <= 1'b0;
                par_flag <= 1'b0;
                frm_flag <= 1'b0;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          DATA: begin
            if (scnt == S_END) begin
              scnt    <= '0;
              shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
              par_acc <= par_acc ^ rxd_s;
              if (bcnt == B_DATA_LAST) begin
                bcnt  <= '0;
                state <= PARITY_EN ? PARITY : STOP;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          PARITY: begin
            if (scnt == S_END) begin
              scnt     <= '0;
              par_flag <= (par_acc ^ rxd_s) != PAR_EXPECT;
              state    <= STOP;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          STOP: begin
            if (scnt == S_END) begin
              scnt <= '0;
              if (bcnt == B_STOP_LAST) begin
                // Last stop sample folds straight into the published flag.
                bcnt       <= '0;
                state      <= IDLE;
                rx_valid   <= 1'b1;
                rx_data    <= shreg;
                parity_err <= par_flag;
                frame_err  <= frm_flag | ~rxd_s;
                par_flag   <= 1'b0;
                frm_flag   <= 1'b0;
              end else begin
                bcnt     <= bcnt + 1'b1;
                frm_flag <= frm_flag | ~rxd_s;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param. Three receivers share one serial line:
//   dut_a  8N1, dut_p 8E1, dut_c 7N2, all CLK_DIV=4, OVERSAMPLE=16 (64 clk/bit).
// Each scenario checks only the receiver whose format it drives; line idle
// gaps let the other receivers drain whatever they made of the traffic.
module tb_uart_rx_param;

  localparam int BIT = 64;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic rx_en = 1'b0;
  logic rxd = 1'b1;

  always #5 clk = ~clk;

  logic [7:0] a_data, p_data;
  logic [6:0] c_data;
  logic a_valid, a_perr, a_ferr, a_busy;
  logic p_valid, p_perr, p_ferr, p_busy;
  logic c_valid, c_perr, c_ferr, c_busy;

  uart_rx_param #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut_a (
    .clk(clk), .n_rst(n_rst), .rx_en(rx_en), .rxd(rxd),
    .rx_data(a_data), .rx_valid(a_valid), .parity_err(a_perr),
    .frame_err(a_ferr), .busy(a_busy));

  uart_rx_param #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut_p (
    .clk(clk), .n_rst(n_rst), .rx_en(rx_en), .rxd(rxd),
    .rx_data(p_data), .rx_valid(p_valid), .parity_err(p_perr),
    .frame_err(p_ferr), .busy(p_busy));

  uart_rx_param #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(7),
                  .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut_c (
    .clk(clk), .n_rst(n_rst), .rx_en(rx_en), .rxd(rxd),
    .rx_data(c_data), .rx_valid(c_valid), .parity_err(c_perr),
    .frame_err(c_ferr), .busy(c_busy));

  int compared = 0;
  int mismatched = 0;

  // Valid-cycle logs: every clk with rx_valid high is one entry, so a
  // stretched pulse shows up as an extra count.
  logic [8:0] a_log_d [64];
  logic       a_log_p [64];
  logic       a_log_f [64];
  int         a_vcnt = 0;
  logic [8:0] p_log_d [64];
  logic       p_log_p [64];
  logic       p_log_f [64];
  int         p_vcnt = 0;
  logic [8:0] c_log_d [64];
  logic       c_log_p [64];
  logic       c_log_f [64];
  int         c_vcnt = 0;
  logic       a_busy_seen = 1'b0;

  always @(negedge clk) begin
    if (a_busy) a_busy_seen = 1'b1;
    if (a_valid) begin
      a_log_d[a_vcnt & 63] = {1'b0, a_data};
      a_log_p[a_vcnt & 63] = a_perr;
      a_log_f[a_vcnt & 63] = a_ferr;
      a_vcnt++;
    end
    if (p_valid) begin
      p_log_d[p_vcnt & 63] = {1'b0, p_data};
      p_log_p[p_vcnt & 63] = p_perr;
      p_log_f[p_vcnt & 63] = p_ferr;
      p_vcnt++;
    end
    if (c_valid) begin
      c_log_d[c_vcnt & 63] = {2'b0, c_data};
      c_log_p[c_vcnt & 63] = c_perr;
      c_log_f[c_vcnt & 63] = c_ferr;
      c_vcnt++;
    end
  end

  task automatic idle(input int nbits);
    rxd = 1'b1;
    repeat (nbits * BIT) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] d, input int nbits, input bit par_en,
                            input logic par_bit, input logic s1, input int nstop,
                            input logic s2);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (par_en) send_bit(par_bit);
    send_bit(s1);
    if (nstop == 2) send_bit(s2);
    rxd = 1'b1;
  endtask

  task automatic test_reset();
    #3 n_rst = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (a_data !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h want 00", a_data); end
    compared++; if (a_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", a_valid); end
    compared++; if (a_perr !== 1'b0 || a_ferr !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b%b want 00", a_perr, a_ferr); end
    compared++; if (a_busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    n_rst = 1'b1;
    rx_en = 1'b1;
    idle(2);
  endtask

  task automatic test_8n1();
    int v0;
    v0 = a_vcnt;
    send_frame(9'h0A5, 8, 0, 1'b0, 1'b1, 1, 1'b1);
    idle(3);
    compared++; if (a_vcnt - v0 !== 1) begin mismatched++; $display("FAIL 8n1_pulses: got %0d want 1", a_vcnt - v0); end
    compared++; if (a_log_d[v0 & 63] !== 9'h0A5) begin mismatched++; $display("FAIL 8n1_data: got %h want 0a5", a_log_d[v0 & 63]); end
    compared++; if (a_log_p[v0 & 63] !== 1'b0 || a_log_f[v0 & 63] !== 1'b0) begin mismatched++; $display("FAIL 8n1_err: got p%b f%b want p0 f0", a_log_p[v0 & 63], a_log_f[v0 & 63]); end
    compared++; if (a_busy !== 1'b0) begin mismatched++; $display("FAIL 8n1_busy_after: got %b want 0", a_busy); end
  endtask

  task automatic test_glitch();
    int v0;
    v0 = a_vcnt;
    a_busy_seen = 1'b0;
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    idle(2);
    compared++; if (a_busy_seen !== 1'b1) begin mismatched++; $display("FAIL glitch_busy_pulse: got %b want 1", a_busy_seen); end
    compared++; if (a_vcnt - v0 !== 0) begin mismatched++; $display("FAIL glitch_pulses: got %0d want 0", a_vcnt - v0); end
    compared++; if (a_data !== 8'hA5) begin mismatched++; $display("FAIL glitch_data_held: got %h want a5", a_data); end
    compared++; if (a_busy !== 1'b0) begin mismatched++; $display("FAIL glitch_idle: got %b want 0", a_busy); end
  endtask

  task automatic test_framing();
    int v0;
    v0 = a_vcnt;
    send_frame(9'h03C, 8, 0, 1'b0, 1'b0, 1, 1'b1);
    idle(3);
    compared++; if (a_vcnt - v0 !== 1) begin mismatched++; $display("FAIL frm_pulses: got %0d want 1", a_vcnt - v0); end
    compared++; if (a_log_d[v0 & 63] !== 9'h03C) begin mismatched++; $display("FAIL frm_data: got %h want 03c", a_log_d[v0 & 63]); end
    compared++; if (a_log_f[v0 & 63] !== 1'b1) begin mismatched++; $display("FAIL frm_ferr: got %b want 1", a_log_f[v0 & 63]); end
    compared++; if (a_ferr !== 1'b1) begin mismatched++; $display("FAIL frm_ferr_held: got %b want 1", a_ferr); end
    v0 = a_vcnt;
    send_frame(9'h055, 8, 0, 1'b0, 1'b1, 1, 1'b1);
    idle(3);
    compared++; if (a_vcnt - v0 !== 1) begin mismatched++; $display("FAIL frm2_pulses: got %0d want 1", a_vcnt - v0); end
    compared++; if (a_log_d[v0 & 63] !== 9'h055 || a_log_f[v0 & 63] !== 1'b0) begin mismatched++; $display("FAIL frm2_data_ferr: got %h f%b want 055 f0", a_log_d[v0 & 63], a_log_f[v0 & 63]); end
  endtask

  task automatic test_abort();
    int v0;
    v0 = a_vcnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rxd = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    rx_en = 1'b0;
    repeat (2) @(negedge clk);
    compared++; if (a_busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy: got %b want 0", a_busy); end
    repeat (BIT / 2) @(negedge clk);
    for (int i = 5; i < 8; i++) send_bit(1'b1);
    send_bit(1'b1);
    idle(2);
    compared++; if (a_vcnt - v0 !== 0) begin mismatched++; $display("FAIL abort_pulses: got %0d want 0", a_vcnt - v0); end
    compared++; if (a_data !== 8'h55) begin mismatched++; $display("FAIL abort_data_held: got %h want 55", a_data); end
    rx_en = 1'b1;
    idle(2);
    v0 = a_vcnt;
    send_frame(9'h012, 8, 0, 1'b0, 1'b1, 1, 1'b1);
    idle(3);
    compared++; if (a_vcnt - v0 !== 1) begin mismatched++; $display("FAIL reen_pulses: got %0d want 1", a_vcnt - v0); end
    compared++; if (a_log_d[v0 & 63] !== 9'h012) begin mismatched++; $display("FAIL reen_data: got %h want 012", a_log_d[v0 & 63]); end
  endtask

  task automatic test_break();
    int v0;
    v0 = a_vcnt;
    rxd = 1'b0;
    repeat (10 * BIT) @(negedge clk);
    idle(3);
    compared++; if (a_vcnt - v0 !== 1) begin mismatched++; $display("FAIL break_pulses: got %0d want 1", a_vcnt - v0); end
    compared++; if (a_log_d[v0 & 63] !== 9'h000 || a_log_f[v0 & 63] !== 1'b1) begin mismatched++; $display("FAIL break_frame: got %h f%b want 000 f1", a_log_d[v0 & 63], a_log_f[v0 & 63]); end
    compared++; if (a_log_p[v0 & 63] !== 1'b0) begin mismatched++; $display("FAIL break_perr: got %b want 0", a_log_p[v0 & 63]); end
  endtask

  task automatic test_parity();
    int v0;
    idle(15);
    v0 = p_vcnt;
    send_frame(9'h007, 8, 1, 1'b0, 1'b1, 1, 1'b1);
    idle(3);
    compared++; if (p_vcnt - v0 !== 1) begin mismatched++; $display("FAIL par_bad_pulses: got %0d want 1", p_vcnt - v0); end
    compared++; if (p_log_d[v0 & 63] !== 9'h007) begin mismatched++; $display("FAIL par_bad_data: got %h want 007", p_log_d[v0 & 63]); end
    compared++; if (p_log_p[v0 & 63] !== 1'b1 || p_log_f[v0 & 63] !== 1'b0) begin mismatched++; $display("FAIL par_bad_err: got p%b f%b want p1 f0", p_log_p[v0 & 63], p_log_f[v0 & 63]); end
    v0 = p_vcnt;
    send_frame(9'h007, 8, 1, 1'b1, 1'b1, 1, 1'b1);
    idle(3);
    compared++; if (p_vcnt - v0 !== 1) begin mismatched++; $display("FAIL par_ok_pulses: got %0d want 1", p_vcnt - v0); end
    compared++; if (p_log_p[v0 & 63] !== 1'b0 || p_log_f[v0 & 63] !== 1'b0) begin mismatched++; $display("FAIL par_ok_err: got p%b f%b want p0 f0", p_log_p[v0 & 63], p_log_f[v0 & 63]); end
    compared++; if (p_perr !== 1'b0) begin mismatched++; $display("FAIL par_ok_held: got %b want 0", p_perr); end
  endtask

  task automatic test_back_to_back();
    int v0;
    idle(15);
    v0 = c_vcnt;
    send_frame(9'h041, 7, 0, 1'b0, 1'b1, 2, 1'b1);
    send_frame(9'h07F, 7, 0, 1'b0, 1'b1, 2, 1'b0);
    idle(3);
    compared++; if (c_vcnt - v0 !== 2) begin mismatched++; $display("FAIL b2b_pulses: got %0d want 2", c_vcnt - v0); end
    compared++; if (c_log_d[v0 & 63] !== 9'h041 || c_log_f[v0 & 63] !== 1'b0 || c_log_p[v0 & 63] !== 1'b0) begin mismatched++; $display("FAIL b2b_frame1: got %h p%b f%b want 041 p0 f0", c_log_d[v0 & 63], c_log_p[v0 & 63], c_log_f[v0 & 63]); end
    compared++; if (c_log_d[(v0 + 1) & 63] !== 9'h07F || c_log_f[(v0 + 1) & 63] !== 1'b1) begin mismatched++; $display("FAIL b2b_frame2: got %h f%b want 07f f1", c_log_d[(v0 + 1) & 63], c_log_f[(v0 + 1) & 63]); end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    idle(15);
    v0 = a_vcnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    n_rst = 1'b0;
    #1;
    compared++; if (a_busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_busy: got %b want 0", a_busy); end
    compared++; if (a_data !== 8'h00 || a_ferr !== 1'b0) begin mismatched++; $display("FAIL rstmid_out: got %h f%b want 00 f0", a_data, a_ferr); end
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    n_rst = 1'b1;
    idle(12);
    compared++; if (a_vcnt - v0 !== 0) begin mismatched++; $display("FAIL rstmid_pulses: got %0d want 0", a_vcnt - v0); end
    compared++; if (a_busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_idle: got %b want 0", a_busy); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_glitch();
    test_framing();
    test_abort();
    test_break();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, next generation of the fixed 8N1 receiver in the UART_CAL path.
- Configurable data width, oversampling ratio, baud divisor, parity and stop-bit count.
- Adds input synchronisation, mid-bit sampling, false-start rejection, and parity/framing error reporting.
- Sits between the board RX pin and the calculator command parser; delivers one word per frame with a single-cycle valid strobe.

Parameters:
CLK_DIV, 27, clk cycles per oversample tick (50 MHz / (115200*16) ≈ 27); legal range >= 1
OVERSAMPLE, 16, ticks per bit period; even, >= 4
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY_EN, 0, 1 = parity bit present after data
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0
STOP_BITS, 1, stop bits checked; legal values 1 or 2

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
rx_en  in  1  receiver enable; low aborts the frame and clears the tick divider
rxd  in  1  asynchronous serial input, idle high
rx_data  out  DATA_BITS  received word, LSB first on the line; held until the next valid
rx_valid  out  1  one-cycle pulse, frame complete
parity_err  out  1  qualified by rx_valid; parity mismatch
frame_err  out  1  qualified by rx_valid; any stop bit sampled low
busy  out  1  high in any state other than IDLE

Behaviour:
Reset and clocking:
- Reset is n_rst, asynchronous, active-low; clock is clk.
- Reset values: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, busy = 0, state IDLE, all counters 0, sync flops = 1.

Synchronisation and tick generation:
- rxd passes through a 2-FF synchroniser to rxd_s; all decisions use rxd_s.
- Tick divider counts 0..CLK_DIV-1 while rx_en = 1; tick = 1 for one clk at CLK_DIV-1, then wraps to 0.
- rx_en = 0 holds the divider at 0.
- Sample counter scnt counts ticks within a bit; bit counter bcnt counts data/stop bits.

State machine (IDLE, START, DATA, PARITY, STOP):
- IDLE: on a tick with rxd_s = 0, go to START and set scnt = 0.
- START: on the tick where scnt = OVERSAMPLE/2-1 (mid start bit):
  - rxd_s = 1 -> IDLE (false start, no outputs change);
  - rxd_s = 0 -> DATA with scnt = 0, bcnt = 0.
- DATA: every OVERSAMPLE ticks (scnt = OVERSAMPLE-1), sample rxd_s into the shift register MSB side, shifting right (LSB first) and increment bcnt.
  - After DATA_BITS samples, go to PARITY if PARITY_EN, else STOP; bcnt resets to 0.
- PARITY: sample one bit after OVERSAMPLE ticks.
  - Error if XOR(data bits, parity bit) != PARITY_ODD.
  - Then go to STOP.
- STOP: sample each stop bit after OVERSAMPLE ticks; any low sample sets the internal frame flag.
  - After STOP_BITS samples, go to IDLE.
  - On the clk following the final stop-sample tick: rx_data <= shift register, parity_err/frame_err <= flags, rx_valid = 1 for exactly one clk.
- Latency: rx_valid rises 1 clk after the tick sampling mid-point of the last stop bit; rxd-to-core adds 2 clk of synchroniser delay.

Boundary conditions:
- rx_en falling in any state: next clk go to IDLE, no rx_valid, rx_data/error outputs unchanged, flags cleared.
- Break (line held low): completes as a frame with data 0 and frame_err = 1.
  - IDLE is re-entered with the line low, so the next tick begins a new START; a false-start check occurs each half-bit until the line returns high.
- Error outputs update only with rx_valid and hold their value otherwise; parity_err is always 0 when PARITY_EN = 0.
- A new start edge is recognised on the first tick in IDLE; back-to-back frames with no idle gap are received without loss.
- Reset asserted mid-frame: immediate return to reset values; no partial data is exposed.

Decomposition:
- Shared package uart_pkg:
  - state typedef/localparams IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4 (3-bit);
  - default baud constants CLK_HZ = 50_000_000, BAUD = 115200;
  - parity-mode constants.
- One natural sub-module: uart_baud_tick (parameter CLK_DIV; ports clk, n_rst, en, tick), reused by the future parametrised transmitter.

Test Plan:
1. CLK_DIV = 4, OVERSAMPLE = 16 (64 clk/bit), 8N1, send 0xA5 -> one rx_valid pulse, rx_data = 0xA5, parity_err = 0, frame_err = 0, busy low after.
2. Low glitch on rxd of 3 ticks (12 clk) in IDLE -> busy pulses briefly, no rx_valid, rx_data unchanged, state back to IDLE.
3. Send 0x3C with stop bit driven 0 -> rx_valid, rx_data = 0x3C, frame_err = 1; then valid 0x55 frame -> frame_err = 0.
4. PARITY_EN = 1, PARITY_ODD = 0, send 0x07 with parity bit 0 -> parity_err = 1; same byte with parity bit 1 -> parity_err = 0.
5. Deassert rx_en at data bit 4 of 0xFF -> no rx_valid; re-enable, send 0x12 -> rx_data = 0x12.
6. DATA_BITS = 7, STOP_BITS = 2, back-to-back 0x41, 0x7F with second stop bit low on frame 2 -> two pulses: 0x41 (no errors), then 0x7F with frame_err = 1.
